// File: rtl/prio_enc_pkg.sv
// Shared definitions for the priority-encoder arbiter: state encoding,
// the clog2 helper and the default parameter values.
// Optional feature macro: PRIO_ENC_RR_EN (round-robin search order).
package prio_enc_pkg;

    localparam int N_DEF        = 8;
    localparam int MAX_HOLD_DEF = 16;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } state_e;

    // Ceiling log2. Returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_arbiter_if.sv
// Request/grant bundle for prio_enc_arbiter.
// Handshake: there is no back-pressure. req is level-sensitive and sampled
// every rising edge; grant_vld/grant_idx/grant_oh are registered and reflect
// the req value of the previous edge. dbg_state/dbg_hold expose the FSM
// state and hold counter for checkers.
interface prio_enc_arbiter_if
    import prio_enc_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
);
    localparam int W  = clog2(N);
    localparam int HW = clog2(MAX_HOLD);

    logic [N-1:0]  req;
    logic          grant_vld;
    logic [W-1:0]  grant_idx;
    logic [N-1:0]  grant_oh;
    state_e        dbg_state;
    logic [HW-1:0] dbg_hold;

    modport master (
        output req,
        input  grant_vld, grant_idx, grant_oh, dbg_state, dbg_hold
    );

    modport slave (
        input  req,
        output grant_vld, grant_idx, grant_oh, dbg_state, dbg_hold
    );

endinterface

// File: rtl/prio_enc_core.sv
// Combinational highest-index-wins priority encoder. This is the only
// priority search in the arbiter; round-robin is done by rotating its input.
module prio_enc_core #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req_m,
    output logic         found,
    output logic [W-1:0] idx
);

    // Ascending scan: the last set bit seen (highest index) wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (req_m[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_enc_arbiter.sv
// Priority-encoder arbiter with grant lock and hold limit.
// A grant is held while the holder keeps requesting, for up to MAX_HOLD
// cycles when others are waiting. Default search is fixed priority (highest
// index wins); defining PRIO_ENC_RR_EN switches to round-robin, where the
// last-granted requester has the lowest priority.
module prio_enc_arbiter
    import prio_enc_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic          clk,
    input  logic          rst,
    prio_enc_arbiter_if.slave bus
);

    localparam int W  = clog2(N);
    localparam int HW = clog2(MAX_HOLD);
    localparam logic [HW-1:0] LIMIT = HW'(MAX_HOLD - 1);

    state_e        state_q, state_n;
    logic [W-1:0]  grant_idx_q, idx_n;
    logic [HW-1:0] hold_q, hold_n;
    logic          vld_q;
    logic [N-1:0]  oh_q;
    logic          new_grant;

    logic [N-1:0]  holder_oh;
    logic          holder_req;
    logic [N-1:0]  cand;
    logic [N-1:0]  search;
    logic          found;
    logic [W-1:0]  core_idx;
    logic [W-1:0]  win_idx;

    assign holder_oh  = N'(1) << grant_idx_q;
    assign holder_req = bus.req[grant_idx_q];

    // Candidate set: at the hold limit the current holder is masked out so
    // another requester can win; otherwise all requests compete.
    always_comb begin
        cand = bus.req;
        if (state_q == GRANT && holder_req && hold_q == LIMIT) begin
            cand = bus.req & ~holder_oh;
        end
    end

`ifdef PRIO_ENC_RR_EN
    localparam int WP = W + 1;
    logic [W-1:0]   ptr_q;
    logic [2*N-1:0] dbl;
    logic [WP-1:0]  sum;

    // Rotate right by ptr so (ptr-1) lands on bit N-1 (top priority) and
    // ptr lands on bit 0; then map the winner back to a real index.
    always_comb begin
        dbl     = {cand, cand} >> ptr_q;
        search  = dbl[N-1:0];
        sum     = {1'b0, core_idx} + {1'b0, ptr_q};
        if (sum >= WP'(N)) sum = sum - WP'(N);
        win_idx = sum[W-1:0];
    end

    // Pointer remembers the most recent new grant.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else if (new_grant) ptr_q <= idx_n;
    end
`else
    assign search  = cand;
    assign win_idx = core_idx;
`endif

    prio_enc_core #(.N(N), .W(W)) u_core (
        .req_m (search),
        .found (found),
        .idx   (core_idx)
    );

    // Next-state: grant, lock, handover on release, re-grant at hold limit.
    always_comb begin
        state_n   = state_q;
        idx_n     = grant_idx_q;
        hold_n    = hold_q;
        new_grant = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_n   = GRANT;
                    idx_n     = win_idx;
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!holder_req) begin
                    if (found) begin
                        idx_n     = win_idx;
                        new_grant = 1'b1;
                    end else begin
                        state_n = IDLE;
                        idx_n   = '0;
                        hold_n  = '0;
                    end
                end else if (hold_q != LIMIT) begin
                    hold_n = hold_q + HW'(1);
                end else if (found) begin
                    // found here means someone other than the holder waits.
                    idx_n     = win_idx;
                    new_grant = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                hold_n  = '0;
            end
        endcase
        if (new_grant) hold_n = '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            hold_q      <= '0;
            vld_q       <= 1'b0;
            oh_q        <= '0;
        end else begin
            state_q     <= state_n;
            grant_idx_q <= idx_n;
            hold_q      <= hold_n;
            vld_q       <= (state_n == GRANT);
            oh_q        <= (state_n == GRANT) ? (N'(1) << idx_n) : '0;
        end
    end

    assign bus.grant_vld = vld_q;
    assign bus.grant_idx = grant_idx_q;
    assign bus.grant_oh  = oh_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_hold  = hold_q;

endmodule

// File: tb/tb_prio_enc_arbiter.sv
// Directed-vector bench for prio_enc_arbiter (N=8, MAX_HOLD=4).
// Driver pushes the hand-computed response for each cycle into exp_q;
// the monitor pops and compares after every rising edge.
module tb_prio_enc_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 4;
    localparam int EW       = 15;  // {chk_hold, hold[1:0], vld, idx[2:0], oh[7:0]}

    logic clk;
    logic rst;

    prio_enc_arbiter_if #(.N(N), .MAX_HOLD(MAX_HOLD)) bus ();

    prio_enc_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [EW-1:0] exp_q[$];
    int tests;
    int fails;

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst     = 1'b1;
        bus.req = 8'hFF;
        tests   = 0;
        fails   = 0;
    end

    // One cycle of stimulus plus the expected result after the next edge.
    task automatic step(input logic r, input logic [7:0] rq, input logic ev,
                        input logic [2:0] ei, input logic ch, input logic [1:0] eh);
        logic [7:0] eoh;
        @(negedge clk);
        rst     = r;
        bus.req = rq;
        eoh     = ev ? (8'b1 << ei) : 8'h00;
        exp_q.push_back({ch, eh, ev, ei, eoh});
    endtask

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Monitor / scoreboard
    always @(posedge clk) begin
        logic [EW-1:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("grant_vld", int'(bus.grant_vld), int'(e[11]));
            check("grant_idx", int'(bus.grant_idx), int'(e[10:8]));
            check("grant_oh",  int'(bus.grant_oh),  int'(e[7:0]));
            if (e[14]) check("hold_cnt", int'(bus.dbg_hold), int'(e[13:12]));
        end
    end

`ifdef PRIO_ENC_RR_EN
    logic [7:0] rr_req[9] = '{8'hFF, 8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [2:0] rr_idx[9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
    logic [7:0] rr_req[4] = '{8'hFF, 8'h7F, 8'hBF, 8'hFF};
    logic [2:0] rr_idx[4] = '{3'd7, 3'd6, 3'd7, 3'd7};
    logic [1:0] rr_hold[4] = '{2'd0, 2'd0, 2'd0, 2'd1};
`endif

    // Directed sequence
    initial begin
        // Reset held with all requests active
        repeat (3) step(1'b1, 8'hFF, 1'b0, 3'd0, 1'b1, 2'd0);
        // Fixed priority from IDLE
        step(1'b0, 8'h26, 1'b1, 3'd5, 1'b1, 2'd0);
        // Lock, then handover without a bubble
        step(1'b0, 8'h21, 1'b1, 3'd5, 1'b1, 2'd1);
        step(1'b0, 8'h21, 1'b1, 3'd5, 1'b1, 2'd2);
        step(1'b0, 8'h01, 1'b1, 3'd0, 1'b1, 2'd0);
        // Release with nobody waiting -> IDLE
        step(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 2'd0);
        // Hold limit with contention: 7 x4, 0 x4, 7
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 8'h81, 1'b1, (i < 4 || i == 8) ? 3'd7 : 3'd0, 1'b1, 2'(i % 4));
        end
        // Sole requester at limit: counter saturates at 3
        step(1'b0, 8'h80, 1'b1, 3'd7, 1'b1, 2'd1);
        step(1'b0, 8'h80, 1'b1, 3'd7, 1'b1, 2'd2);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h80, 1'b1, 3'd7, 1'b1, 2'd3);
        // Move grant to 3, then reset mid-grant
        step(1'b0, 8'h08, 1'b1, 3'd3, 1'b1, 2'd0);
        step(1'b0, 8'h08, 1'b1, 3'd3, 1'b1, 2'd1);
        step(1'b1, 8'h08, 1'b0, 3'd0, 1'b1, 2'd0);
        step(1'b0, 8'h88, 1'b1, 3'd7, 1'b1, 2'd0);
        // Fresh reset, then release-driven rotation
        step(1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 2'd0);
`ifdef PRIO_ENC_RR_EN
        for (int i = 0; i < 9; i++) step(1'b0, rr_req[i], 1'b1, rr_idx[i], 1'b1, 2'd0);
`else
        for (int i = 0; i < 4; i++) step(1'b0, rr_req[i], 1'b1, rr_idx[i], 1'b1, rr_hold[i]);
`endif
        step(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 2'd0);

        // Drain, bounded
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prio_enc_arbiter.md
PRIO_ENC_ARBITER -- requirements
Module: prio_enc_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter N, default 8: number of request lines; legal values are 2..32.
REQ-003 Parameter MAX_HOLD, default 16: maximum number of consecutive grant cycles while other requests are pending; legal values are >=2.
REQ-004 Derived constant W = clog2(N): width of the grant index.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst, input, 1: synchronous active-high reset.
REQ-007 Port req, input, N: request lines; req[i] high means requester i wants the resource.
REQ-008 Port grant_vld, output, 1: a grant is active.
REQ-009 Port grant_idx, output, W: index of the granted requester.
REQ-010 Port grant_oh, output, N: one-hot copy of grant_idx, qualified by grant_vld.

Function
REQ-011 All outputs SHALL be registered; the arbitration result SHALL appear exactly 1 cycle after the req value that caused it.
REQ-012 The state machine SHALL have two states, IDLE and GRANT.
REQ-013 IDLE -> GRANT: when any req bit is high, grant the winner.
REQ-014 IDLE stays in IDLE when req == 0; in IDLE, grant_vld = 0, grant_idx = 0 and grant_oh = 0.
REQ-015 Fixed priority: the highest-numbered active req bit SHALL win (req[N-1] has the highest priority).
REQ-016 GRANT, lock: while req[grant_idx] stays high and the hold counter is below MAX_HOLD-1, the grant SHALL be held unchanged regardless of other req bits.
REQ-017 GRANT, release: when req[grant_idx] is low, the block SHALL re-arbitrate among the current req bits in the same cycle.
 - Any request present: stay in GRANT with the new winner, with no idle bubble.
 - No request: go to IDLE.
REQ-018 Hold counter: the counter SHALL reset to 0 on every new grant and increment on every held cycle.
REQ-019 Hold-limit expiry: when the counter equals MAX_HOLD-1, the holder's req is still high, and another req bit is high, the block SHALL re-grant to the winner among req with the holder masked out.
REQ-020 Hold-limit, no contention: when the holder is the only requester at the limit, it SHALL keep the grant and the counter SHALL saturate at MAX_HOLD-1.
REQ-021 grant_oh SHALL always equal the one-hot decode of grant_idx when grant_vld = 1, and SHALL be all-zero otherwise.
REQ-022 An X or Z value on req is out of scope; no wildcard matching is permitted on req decode.

Reset
REQ-023 When rst = 1 at a clock edge, the following SHALL be set regardless of req:
 - state = IDLE;
 - grant_vld = 0, grant_idx = 0, grant_oh = 0;
 - hold counter = 0;
 - round-robin pointer = 0.
REQ-024 Reset asserted mid-grant SHALL drop grant_vld on the next edge.
REQ-025 The first arbitration after reset release SHALL use req sampled in the cycle after rst falls.

Configuration
REQ-026 Macro PRIO_ENC_RR_EN, when defined, SHALL replace the fixed priority of REQ-015 with round-robin.
 - A pointer register holds the last granted index.
 - The search SHALL run in descending order starting at (pointer-1) mod N and wrap from 0 to N-1; the last-granted requester therefore has the lowest priority.
 - The pointer SHALL update on every new grant.
REQ-027 With PRIO_ENC_RR_EN defined, the pointer reset value of 0 SHALL make the first arbitration identical to fixed priority.
REQ-028 Without PRIO_ENC_RR_EN, no pointer register SHALL be synthesised and behaviour SHALL be pure fixed priority; the lock and hold-limit rules SHALL apply in both builds.

Structure
REQ-029 Shared package prio_enc_pkg SHALL hold:
 - the IDLE/GRANT state encoding localparams;
 - the clog2 function;
 - the default values for N and MAX_HOLD.
REQ-030 Sub-module prio_enc_core SHALL be the only priority-search logic.
 - It is a combinational N-wide highest-index-wins encoder.
 - Inputs: the masked request vector. Outputs: found and idx.
 - Round-robin SHALL be built by rotating or masking the request vector ahead of prio_enc_core, not by a second encoder.

Verification (N=8, MAX_HOLD=4)
REQ-031 Reset: rst=1 with req=8'hFF -> grant_vld=0, grant_idx=0 and grant_oh=0 on every edge while rst is high.
REQ-032 Fixed priority: req=8'b0010_0110 from IDLE -> one cycle later grant_vld=1, grant_idx=5, grant_oh=8'h20.
REQ-033 Lock and back-to-back handover, fixed build:
 - Hold req=8'h21 with idx 5 granted -> the grant is held.
 - Drop bit 5 so req=8'h01 -> grant_idx=0 on the next edge with grant_vld continuously 1.
REQ-034 Hold limit: req=8'h81 held constant -> grant_idx=7 for 4 cycles, then 0 for 4 cycles, then 7 again, alternating.
 - Variant: req=8'h80 alone -> grant_idx=7 for all cycles and the counter stays at 3.
REQ-035 Round-robin build: req=8'hFF held and each holder drops its request for one cycle after its grant -> grant_idx sequence 7,6,5,4,3,2,1,0,7.
REQ-036 Reset mid-grant: with grant_idx=3 active, pulse rst for 1 cycle.
 - grant_vld falls on that edge.
 - With PRIO_ENC_RR_EN defined, the first post-reset grant for req=8'h88 is 7.
